// File: rtl/sm_irq_ctrl_if.sv
// rtl/sm_irq_ctrl_if.sv - register bus interface for the interrupt controller
interface sm_irq_ctrl_if;
  logic [2:0]  regAddr;
  logic        regWe;
  logic [31:0] regWData;
  logic [31:0] regRData;

  modport master (output regAddr, output regWe, output regWData, input regRData);
  modport slave  (input regAddr, input regWe, input regWData, output regRData);
endinterface

// File: rtl/sm_irq_ctrl.sv
// rtl/sm_irq_ctrl.sv - synchronised edge/level interrupt controller with fixed-priority id
module sm_irq_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irqIn,
  sm_irq_ctrl_if.slave       bus,
  output logic               irq,
  output logic [4:0]         irqId
);

  localparam logic [2:0] ADDR_PEND   = 3'd0;
  localparam logic [2:0] ADDR_ENABLE = 3'd1;
  localparam logic [2:0] ADDR_MODE   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_FORCE  = 3'd4;
  // Edge detection stays masked until the synchroniser has been refilled with
  // post-reset samples, so a line already high at release is not an edge.
  localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q, sync_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [2:0]         settle_q, settle_d;
  logic               irq_q, irq_d;
  logic [4:0]         irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0] sync, pend, active, wdata;
  logic [NUM_IRQ-1:0] rise, set_mask, clr_mask, mode_chg;
  logic               wr_pend, wr_enable, wr_mode, wr_force;
  logic               unused_wdata;

  assign sync         = sync_q[SYNC_STAGES-1];
  assign wdata        = bus.regWData[NUM_IRQ-1:0];
  assign unused_wdata = ^bus.regWData;

  // Register write decode
  always_comb begin
    wr_pend   = bus.regWe && (bus.regAddr == ADDR_PEND);
    wr_enable = bus.regWe && (bus.regAddr == ADDR_ENABLE);
    wr_mode   = bus.regWe && (bus.regAddr == ADDR_MODE);
    wr_force  = bus.regWe && (bus.regAddr == ADDR_FORCE);
  end

  // Pending view: edge channels use the stored bit, level channels follow sync
  always_comb begin
    pend   = (edge_pend_q & mode_q) | (sync & ~mode_q);
    active = pend & enable_q;
  end

  // Next-state logic for synchroniser, config registers, edge pending and outputs
  always_comb begin
    sync_d[0] = irqIn;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d    = sync;
    settle_d  = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 3'd1;
    enable_d  = wr_enable ? wdata : enable_q;
    mode_d    = wr_mode ? wdata : mode_q;
    mode_chg  = mode_q ^ mode_d;

    rise      = (settle_q == SETTLE_DONE) ? (sync & ~prev_q) : '0;
    set_mask  = (rise | (wr_force ? wdata : '0)) & mode_q;
    clr_mask  = wr_pend ? wdata : '0;
    // Set beats clear; a mode change always drops the stored bit
    edge_pend_d = ((edge_pend_q & ~clr_mask) | set_mask) & ~mode_chg;

    irq_d    = |active;
    irq_id_d = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) irq_id_d = 5'(i);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      prev_q      <= '0;
      edge_pend_q <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      settle_q    <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= 5'd0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      edge_pend_q <= edge_pend_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      settle_q    <= settle_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
    end
  end

  // Combinational read mux; unmapped addresses and unused bits read 0
  always_comb begin
    bus.regRData = '0;
    case (bus.regAddr)
      ADDR_PEND:   bus.regRData[NUM_IRQ-1:0] = pend;
      ADDR_ENABLE: bus.regRData[NUM_IRQ-1:0] = enable_q;
      ADDR_MODE:   bus.regRData[NUM_IRQ-1:0] = mode_q;
      ADDR_STATUS: bus.regRData = {irq_q, 26'b0, irq_id_q};
      default:     bus.regRData = '0;
    endcase
  end

  assign irq   = irq_q;
  assign irqId = irq_id_q;

endmodule

// File: tb/tb_sm_irq_ctrl.sv
// tb/tb_sm_irq_ctrl.sv - directed self-checking bench for sm_irq_ctrl
module tb_sm_irq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sm_irq_ctrl_if if_a ();
  sm_irq_ctrl_if if_b ();
  sm_irq_ctrl_if if_c ();

  logic [7:0]  irq_in_a;
  logic [31:0] irq_in_b;
  logic [2:0]  irq_in_c;
  logic        irq_a, irq_b, irq_c;
  logic [4:0]  id_a, id_b, id_c;

  sm_irq_ctrl #(.NUM_IRQ(8), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .irqIn(irq_in_a), .bus(if_a.slave), .irq(irq_a), .irqId(id_a));
  sm_irq_ctrl #(.NUM_IRQ(32), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .irqIn(irq_in_b), .bus(if_b.slave), .irq(irq_b), .irqId(id_b));
  sm_irq_ctrl #(.NUM_IRQ(3), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .irqIn(irq_in_c), .bus(if_c.slave), .irq(irq_c), .irqId(id_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
    if_a.regAddr = a; if_a.regWData = d; if_a.regWe = 1'b1;
    tick(1);
    if_a.regWe = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
    if_b.regAddr = a; if_b.regWData = d; if_b.regWe = 1'b1;
    tick(1);
    if_b.regWe = 1'b0;
  endtask

  task automatic wr_c(input logic [2:0] a, input logic [31:0] d);
    if_c.regAddr = a; if_c.regWData = d; if_c.regWe = 1'b1;
    tick(1);
    if_c.regWe = 1'b0;
  endtask

  task automatic rd_chk_a(input string tag, input logic [2:0] a, input logic [31:0] exp);
    if_a.regAddr = a;
    #1;
    chk(tag, if_a.regRData, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    irq_in_a = '0; irq_in_b = '0; irq_in_c = '0;
    if_a.regAddr = '0; if_a.regWe = 1'b0; if_a.regWData = '0;
    if_b.regAddr = '0; if_b.regWe = 1'b0; if_b.regWData = '0;
    if_c.regAddr = '0; if_c.regWe = 1'b0; if_c.regWData = '0;

    // Reset state
    tick(3);
    chk("rst_irq", {31'b0, irq_a}, 32'd0);
    chk("rst_id", {27'b0, id_a}, 32'd0);
    rd_chk_a("rst_status", 3'd3, 32'd0);
    rd_chk_a("rst_enable", 3'd1, 32'd0);
    rd_chk_a("rst_mode", 3'd2, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Edge pulse on channel 0: pending after edge 3, irq after edge 4
    wr_a(3'd1, 32'h01);
    wr_a(3'd2, 32'h01);
    irq_in_a[0] = 1'b1;
    tick(1);
    irq_in_a[0] = 1'b0;
    tick(2);
    rd_chk_a("edge_pend_e3", 3'd0, 32'h01);
    chk("edge_irq_e3", {31'b0, irq_a}, 32'd0);
    tick(1);
    chk("edge_irq_e4", {31'b0, irq_a}, 32'd1);
    rd_chk_a("edge_status", 3'd3, 32'h8000_0000);
    wr_a(3'd0, 32'h01);
    rd_chk_a("edge_pend_clr", 3'd0, 32'h00);
    chk("edge_irq_hold", {31'b0, irq_a}, 32'd1);
    tick(1);
    chk("edge_irq_drop", {31'b0, irq_a}, 32'd0);

    // Priority: channels 5 and 2 together
    wr_a(3'd1, 32'hFF);
    wr_a(3'd2, 32'hFF);
    irq_in_a[5] = 1'b1; irq_in_a[2] = 1'b1;
    tick(4);
    chk("prio_irq", {31'b0, irq_a}, 32'd1);
    chk("prio_id2", {27'b0, id_a}, 32'd2);
    wr_a(3'd0, 32'h04);
    tick(1);
    chk("prio_id5", {27'b0, id_a}, 32'd5);
    wr_a(3'd0, 32'h20);
    tick(1);
    chk("prio_irq_off", {31'b0, irq_a}, 32'd0);
    chk("prio_id_off", {27'b0, id_a}, 32'd0);
    irq_in_a[5] = 1'b0; irq_in_a[2] = 1'b0;
    tick(3);

    // Level channel 3: clear has no effect, drop removes irq after 3 edges
    wr_a(3'd2, 32'h00);
    wr_a(3'd1, 32'h08);
    irq_in_a[3] = 1'b1;
    tick(4);
    chk("lvl_irq", {31'b0, irq_a}, 32'd1);
    wr_a(3'd0, 32'h08);
    tick(1);
    chk("lvl_irq_after_clr", {31'b0, irq_a}, 32'd1);
    rd_chk_a("lvl_pend", 3'd0, 32'h08);
    wr_a(3'd4, 32'h08);
    rd_chk_a("lvl_force_noeff", 3'd0, 32'h08);
    irq_in_a[3] = 1'b0;
    tick(2);
    chk("lvl_irq_e2", {31'b0, irq_a}, 32'd1);
    tick(1);
    chk("lvl_irq_e3", {31'b0, irq_a}, 32'd0);

    // Set beats clear on edge channel 1
    wr_a(3'd1, 32'h00);
    wr_a(3'd2, 32'h02);
    irq_in_a[1] = 1'b1;
    tick(2);
    wr_a(3'd0, 32'h02);
    rd_chk_a("set_wins", 3'd0, 32'h02);
    wr_a(3'd0, 32'h02);
    rd_chk_a("clr_after", 3'd0, 32'h00);
    irq_in_a[1] = 1'b0;
    tick(3);

    // FORCE latency, disable/re-enable, unmapped addresses
    wr_a(3'd1, 32'h02);
    wr_a(3'd4, 32'h02);
    rd_chk_a("force_pend", 3'd0, 32'h02);
    chk("force_irq_e1", {31'b0, irq_a}, 32'd0);
    tick(1);
    chk("force_irq_e2", {31'b0, irq_a}, 32'd1);
    chk("force_id", {27'b0, id_a}, 32'd1);
    wr_a(3'd1, 32'h00);
    tick(1);
    chk("dis_irq", {31'b0, irq_a}, 32'd0);
    rd_chk_a("dis_pend_kept", 3'd0, 32'h02);
    wr_a(3'd1, 32'h02);
    tick(1);
    chk("reen_irq", {31'b0, irq_a}, 32'd1);
    rd_chk_a("force_reads0", 3'd4, 32'd0);
    wr_a(3'd6, 32'hFF);
    rd_chk_a("addr6_read0", 3'd6, 32'd0);
    rd_chk_a("addr6_wr_ignored", 3'd1, 32'h02);
    wr_a(3'd0, 32'h02);
    tick(2);

    // Asynchronous reset mid-pulse, line held high through release
    wr_a(3'd2, 32'h01);
    wr_a(3'd1, 32'h01);
    wr_a(3'd4, 32'h01);
    tick(1);
    chk("pre_rst_irq", {31'b0, irq_a}, 32'd1);
    irq_in_a[0] = 1'b1;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_irq", {31'b0, irq_a}, 32'd0);
    chk("async_rst_id", {27'b0, id_a}, 32'd0);
    rd_chk_a("async_rst_pend", 3'd0, 32'd0);
    tick(2);
    rst_n = 1'b1;
    wr_a(3'd2, 32'h01);
    wr_a(3'd1, 32'h01);
    tick(6);
    rd_chk_a("no_edge_after_rst", 3'd0, 32'd0);
    chk("no_irq_after_rst", {31'b0, irq_a}, 32'd0);
    irq_in_a[0] = 1'b0;

    // Width boundaries: 32 channels and 3 channels
    wr_b(3'd1, 32'h8000_0000);
    wr_b(3'd2, 32'h8000_0000);
    wr_b(3'd4, 32'h8000_0000);
    tick(1);
    chk("b_irq", {31'b0, irq_b}, 32'd1);
    chk("b_id31", {27'b0, id_b}, 32'd31);
    wr_c(3'd1, 32'hFFFF_FFFF);
    if_c.regAddr = 3'd1;
    #1;
    chk("c_enable_mask", if_c.regRData, 32'h7);
    wr_c(3'd2, 32'hFFFF_FFF8);
    if_c.regAddr = 3'd2;
    #1;
    chk("c_mode_hi_ignored", if_c.regRData, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
